// File: rtl/module_regfile_sb_pkg.sv
// regfile_pkg: default geometry, address-width helper and register types
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int NREGS = 32;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int AW = clog2(NREGS);
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/module_regfile_sb_if.sv
// module_regfile_sb_if: decode/writeback bus of the register file and scoreboard
interface module_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int AW = 5,
  parameter int NRD = 2,
  parameter int NWR = 1
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic [NWR-1:0] wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic iss_en;
  logic [AW-1:0] iss_addr;
  logic flush;
  logic busy_any;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input rd_data, rd_busy, busy_any
  );
  modport slave (
    input rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_any
  );
endinterface

// File: rtl/module_regfile_sb_scoreboard.sv
// module_regfile_scoreboard: pending-write busy vector with issue/writeback/flush priority
module module_regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS = 32,
  parameter int AW = 5,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic iss_en,
  input  logic [AW-1:0] iss_addr,
  input  logic flush,
  input  logic [NWR-1:0] wr_ok,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0] rd_busy,
  output logic busy_any
);
  logic [NREGS-1:0] busy, set, clr, busy_n;
  always_comb begin
    set = '0;
    clr = '0;
    if (iss_en && !(ZERO_REG != 0 && iss_addr == '0)) set[iss_addr] = 1'b1;
    for (int j = 0; j < NWR; j++)
      if (wr_ok[j]) clr[wr_addr[j*AW +: AW]] = 1'b1;
    busy_n = set | (busy & ~clr);
  end
  always_ff @(posedge clk_i)
    busy <= (rst_i || flush) ? '0 : busy_n;
  // lookahead busy ignores flush so decode sees the producer it just issued
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[k*AW +: AW];
    assign rd_busy[k] = (ZERO_REG != 0 && a == '0) ? 1'b0 :
                        (BYPASS != 0 && !rst_i) ? busy_n[a] : busy[a];
  end
  assign busy_any = |busy;
endmodule

// File: rtl/module_regfile_sb.sv
// module_regfile_sb: multi-port register file with write bypass and pending-write scoreboard
module module_regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic clk_i,
  input logic rst_i,
  module_regfile_sb_if.slave bus
);
  localparam int AW = clog2(NREGS);
  logic [DATA_W-1:0] rf [NREGS];
  logic [AW-1:0] wa [NWR];
  logic [DATA_W-1:0] wd [NWR];
  logic [NWR-1:0] wr_ok;
  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j] = bus.wr_addr[j*AW +: AW];
    assign wd[j] = bus.wr_data[j*DATA_W +: DATA_W];
    assign wr_ok[j] = bus.wr_en[j] && !(ZERO_REG != 0 && wa[j] == '0);
  end
  // later ports assigned last so the highest enabled port wins a collision
  always_ff @(posedge clk_i)
    if (rst_i)
      for (int r = 0; r < NREGS; r++) rf[r] <= '0;
    else
      for (int j = 0; j < NWR; j++)
        if (wr_ok[j]) rf[wa[j]] <= wd[j];
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = bus.rd_addr[k*AW +: AW];
    always_comb begin
      d = rf[a];
      for (int j = 0; j < NWR; j++)
        if (BYPASS != 0 && !rst_i && wr_ok[j] && wa[j] == a) d = wd[j];
      if (ZERO_REG != 0 && a == '0) d = '0;
    end
    assign bus.rd_data[k*DATA_W +: DATA_W] = d;
  end
  module_regfile_scoreboard #(
    .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_sb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .iss_en(bus.iss_en),
    .iss_addr(bus.iss_addr),
    .flush(bus.flush),
    .wr_ok(wr_ok),
    .wr_addr(bus.wr_addr),
    .rd_addr(bus.rd_addr),
    .rd_busy(bus.rd_busy),
    .busy_any(bus.busy_any)
  );
endmodule
